// File: rtl/rw_runlen_resumption.sv
// Multi-tag resumption machine that run-length encodes a W-bit sample stream into {value, count} words.
// Optional REWIRE_HALT_EN: halts after LIMIT emitted runs and exposes __continue.
module rw_runlen_resumption #(
  parameter int unsigned W     = 2,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     __in0,
  input  logic             __in1,
  output logic [W-1:0]     __out0,
  output logic [CNT_W-1:0] __out1,
  output logic             __out2
`ifdef REWIRE_HALT_EN
  ,
  output logic             __continue
`endif
);

  typedef enum logic [1:0] {
    TAG_HALT    = 2'h0,
    TAG_INIT    = 2'h1,
    TAG_RUN     = 2'h2,
    TAG_ILLEGAL = 2'h3
  } tag_t;

  localparam logic [CNT_W-1:0] RUN_MAX = '1;
  localparam logic [CNT_W-1:0] RUN_ONE = CNT_W'(1);

  tag_t             __resumption_tag, tag_n;
  logic [W-1:0]     last, last_n;
  logic [CNT_W-1:0] run, run_n;
  logic             emit;

`ifdef REWIRE_HALT_EN
  localparam int unsigned EC_W = $clog2(LIMIT + 1);
  logic [EC_W-1:0] emit_cnt, emit_cnt_n;
  logic            halt_now;
`else
  // LIMIT has no effect when halting is compiled out.
  if (LIMIT == 0) begin : g_limit_unused
  end
`endif

  // Next-state function of {tag, last, run, __in0, __in1}.
  always_comb begin
    tag_n  = __resumption_tag;
    last_n = last;
    run_n  = run;
    emit   = 1'b0;
    case (__resumption_tag)
      TAG_INIT: begin
        last_n = __in0;
        run_n  = RUN_ONE;
        tag_n  = TAG_RUN;
      end
      TAG_RUN: begin
        if (__in1) begin
          emit  = 1'b1;
          tag_n = TAG_INIT;
        end else if (__in0 != last) begin
          emit   = 1'b1;
          last_n = __in0;
          run_n  = RUN_ONE;
        end else if (run == RUN_MAX) begin
          // Saturated run is emitted; the current sample opens the next run.
          emit  = 1'b1;
          run_n = RUN_ONE;
        end else begin
          run_n = run + RUN_ONE;
        end
      end
      TAG_HALT: begin
      end
      default: tag_n = TAG_INIT;
    endcase
`ifdef REWIRE_HALT_EN
    emit_cnt_n = emit ? emit_cnt + EC_W'(1) : emit_cnt;
    halt_now   = emit && (emit_cnt_n == EC_W'(LIMIT));
    if (halt_now) tag_n = TAG_HALT;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      __resumption_tag <= TAG_INIT;
      last             <= '0;
      run              <= '0;
      __out0           <= '0;
      __out1           <= '0;
      __out2           <= 1'b0;
    end else begin
      __resumption_tag <= tag_n;
      last             <= last_n;
      run              <= run_n;
      __out2           <= emit;
      if (emit) begin
        __out0 <= last;
        __out1 <= run;
      end
    end
  end

`ifdef REWIRE_HALT_EN
  // Emit counter and continue flag; the LIMIT-th emit drops __continue on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      emit_cnt   <= '0;
      __continue <= 1'b1;
    end else begin
      emit_cnt <= emit_cnt_n;
      if (halt_now) __continue <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_rw_runlen_resumption.sv
// Scoreboard bench for rw_runlen_resumption (W=2, CNT_W=4); expected emits queued as stimulus is driven.
module tb_rw_runlen_resumption;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in0;
  logic       in1;
  logic [1:0] out0;
  logic [3:0] out1;
  logic       out2;
`ifdef REWIRE_HALT_EN
  logic       cont;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [1:0] v;
    logic [3:0] c;
  } emit_t;

  emit_t exp_q[$];

  always #5 clk = ~clk;

  rw_runlen_resumption #(
    .W(2), .CNT_W(4)
`ifdef REWIRE_HALT_EN
    , .LIMIT(2)
`endif
  ) dut (
    .clk(clk), .rst(rst), .__in0(in0), .__in1(in1),
    .__out0(out0), .__out1(out1), .__out2(out2)
`ifdef REWIRE_HALT_EN
    , .__continue(cont)
`endif
  );

  task automatic step(input logic [1:0] d, input logic f);
    in0 = d;
    in1 = f;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    in0 = '0;
    in1 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset;
    emit_t e;
    rst = 1'b1; in0 = '0; in1 = 1'b0;
    #2;
    n_cmp++;
    if ({out2, out0, out1} !== 7'd0 || 2'(dut.__resumption_tag) !== 2'h1) begin
      n_bad++;
      $display("FAIL reset_initial: out2=%b out0=%0d out1=%0d tag=%0d, need all 0 and tag 1",
               out2, out0, out1, 2'(dut.__resumption_tag));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    step(2'd1, 1'b0);
    n_cmp++;
    if (out2 !== 1'b0 || dut.last !== 2'd1 || dut.run !== 4'd1) begin
      n_bad++;
      $display("FAIL reset_first_sample: out2=%b last=%0d run=%0d, need 0/1/1", out2, dut.last, dut.run);
    end
    exp_q.push_back('{v: 2'd1, c: 4'd1});
    step(2'd2, 1'b0);
    e = exp_q.pop_front();
    n_cmp++;
    if ({out2, out0, out1} !== {1'b1, e.v, e.c}) begin
      n_bad++;
      $display("FAIL reset_pre_emit: out2=%b val=%0d cnt=%0d, need emit val=%0d cnt=%0d", out2, out0, out1, e.v, e.c);
    end
    // Mid-cycle reset must clear everything before the next edge.
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({out2, out0, out1} !== 7'd0 || 2'(dut.__resumption_tag) !== 2'h1 ||
        dut.last !== 2'd0 || dut.run !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_async: out2=%b out0=%0d out1=%0d tag=%0d last=%0d run=%0d, need zeros and tag 1",
               out2, out0, out1, 2'(dut.__resumption_tag), dut.last, dut.run);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    step(2'd3, 1'b0);
    n_cmp++;
    if (out2 !== 1'b0 || dut.last !== 2'd3 || dut.run !== 4'd1) begin
      n_bad++;
      $display("FAIL reset_release: out2=%b last=%0d run=%0d, need 0/3/1", out2, dut.last, dut.run);
    end
  endtask

  task automatic test_simple_run;
    logic [1:0] s [5] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
    emit_t e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i == 3) exp_q.push_back('{v: 2'd1, c: 4'd3});
      step(s[i], 1'b0);
      n_cmp++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if ({out2, out0, out1} !== {1'b1, e.v, e.c}) begin
          n_bad++;
          $display("FAIL simple[%0d]: out2=%b val=%0d cnt=%0d, need emit val=%0d cnt=%0d", i, out2, out0, out1, e.v, e.c);
        end
      end else if (out2 !== 1'b0 || (i == 4 && (out0 !== 2'd1 || out1 !== 4'd3))) begin
        n_bad++;
        $display("FAIL simple[%0d]: out2=%b val=%0d cnt=%0d, need no emit", i, out2, out0, out1);
      end
    end
  endtask

  task automatic test_saturation;
    emit_t e;
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      if (k == 16) exp_q.push_back('{v: 2'd3, c: 4'd15});
      step(2'd3, 1'b0);
      n_cmp++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if ({out2, out0, out1} !== {1'b1, e.v, e.c}) begin
          n_bad++;
          $display("FAIL saturation[%0d]: out2=%b val=%0d cnt=%0d, need emit val=%0d cnt=%0d", k, out2, out0, out1, e.v, e.c);
        end
      end else if (out2 !== 1'b0) begin
        n_bad++;
        $display("FAIL saturation[%0d]: out2=%b, need 0", k, out2);
      end
    end
    n_cmp++;
    if (dut.run !== 4'd2) begin
      n_bad++;
      $display("FAIL saturation_run: run=%0d, need 2", dut.run);
    end
  endtask

  task automatic test_flush;
    logic [1:0] s [5] = '{2'd2, 2'd2, 2'd0, 2'd1, 2'd3};
    logic       f [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    emit_t e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) exp_q.push_back('{v: 2'd2, c: 4'd2});
      if (i == 4) exp_q.push_back('{v: 2'd1, c: 4'd1});
      step(s[i], f[i]);
      n_cmp++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if ({out2, out0, out1} !== {1'b1, e.v, e.c}) begin
          n_bad++;
          $display("FAIL flush[%0d]: out2=%b val=%0d cnt=%0d, need emit val=%0d cnt=%0d", i, out2, out0, out1, e.v, e.c);
        end
      end else if (out2 !== 1'b0) begin
        n_bad++;
        $display("FAIL flush[%0d]: out2=%b, need 0", i, out2);
      end
      if (i == 2) begin
        n_cmp++;
        if (2'(dut.__resumption_tag) !== 2'h1) begin
          n_bad++;
          $display("FAIL flush_tag: tag=%0d, need 1", 2'(dut.__resumption_tag));
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] s [5] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
    emit_t e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) exp_q.push_back('{v: s[i-1], c: 4'd1});
      step(s[i], 1'b0);
      n_cmp++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if ({out2, out0, out1} !== {1'b1, e.v, e.c}) begin
          n_bad++;
          $display("FAIL b2b[%0d]: out2=%b val=%0d cnt=%0d, need emit val=%0d cnt=%0d", i, out2, out0, out1, e.v, e.c);
        end
      end else if (out2 !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b[%0d]: out2=%b, need 0", i, out2);
      end
    end
  endtask

  // Random stream checked against a behavioural RLE reference.
  task automatic test_random;
    bit         m_active = 1'b0;
    logic [1:0] m_last = '0;
    int         m_run = 0;
    logic [1:0] d = '0;
    logic       f;
    emit_t      e;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(5) == 0) d = 2'($urandom_range(3));
      f = ($urandom_range(19) == 0);
      if (!m_active) begin
        m_active = 1'b1; m_last = d; m_run = 1;
      end else if (f) begin
        exp_q.push_back('{v: m_last, c: 4'(m_run)}); m_active = 1'b0;
      end else if (d != m_last) begin
        exp_q.push_back('{v: m_last, c: 4'(m_run)}); m_last = d; m_run = 1;
      end else if (m_run == 15) begin
        exp_q.push_back('{v: m_last, c: 4'd15}); m_run = 1;
      end else begin
        m_run++;
      end
      step(d, f);
      n_cmp++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if ({out2, out0, out1} !== {1'b1, e.v, e.c}) begin
          n_bad++;
          $display("FAIL random[%0d]: out2=%b val=%0d cnt=%0d, need emit val=%0d cnt=%0d", i, out2, out0, out1, e.v, e.c);
        end
      end else if (out2 !== 1'b0) begin
        n_bad++;
        $display("FAIL random[%0d]: out2=%b, need 0", i, out2);
      end
    end
  endtask

`ifdef REWIRE_HALT_EN
  task automatic test_halt;
    logic [1:0] s [7] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2};
    emit_t e;
    logic  exp_cont;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i == 1 || i == 2) exp_q.push_back('{v: s[i-1], c: 4'd1});
      exp_cont = (i < 2);
      step(s[i], 1'b0);
      n_cmp++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if ({out2, out0, out1, cont} !== {1'b1, e.v, e.c, exp_cont}) begin
          n_bad++;
          $display("FAIL halt[%0d]: out2=%b val=%0d cnt=%0d cont=%b, need emit val=%0d cnt=%0d cont=%b",
                   i, out2, out0, out1, cont, e.v, e.c, exp_cont);
        end
      end else if (out2 !== 1'b0 || cont !== exp_cont) begin
        n_bad++;
        $display("FAIL halt[%0d]: out2=%b cont=%b, need 0/%b", i, out2, cont, exp_cont);
      end
    end
    n_cmp++;
    if (2'(dut.__resumption_tag) !== 2'h0) begin
      n_bad++;
      $display("FAIL halt_tag: tag=%0d, need 0", 2'(dut.__resumption_tag));
    end
    do_reset();
    n_cmp++;
    if (cont !== 1'b1 || 2'(dut.__resumption_tag) !== 2'h1) begin
      n_bad++;
      $display("FAIL halt_release: cont=%b tag=%0d, need 1/1", cont, 2'(dut.__resumption_tag));
    end
  endtask
`endif

  initial begin
    rst = 1'b0;
    in0 = '0;
    in1 = 1'b0;
    #1;
    test_reset();
`ifdef REWIRE_HALT_EN
    test_halt();
`else
    test_simple_run();
    test_saturation();
    test_flush();
    test_back_to_back();
    test_random();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
